// File: rtl/trig_ldac_sched_if.sv
// rtl/trig_ldac_sched_if.sv - trigger/LDAC scheduler signal bundle
interface trig_ldac_sched_if #(
   parameter int NUM_BOARDS = 8,
   parameter int LOCKOUT_W  = 25
);
   logic                  enable;
   logic [NUM_BOARDS-1:0] board_mask;
   logic [LOCKOUT_W-1:0]  lockout_cycles;
   logic                  count_clr;
   logic                  ext_trig;
   logic [NUM_BOARDS-1:0] trig_waiting;
   logic [NUM_BOARDS-1:0] board_ldac;
   logic                  trigger;
   logic                  ldac_shared;
   logic [31:0]           trig_count;
   logic                  missed_trig;
   logic                  ldac_skew;
   logic [1:0]            state;

   // Host/board side: drives control and status, observes scheduler results
   modport master (
      output enable, board_mask, lockout_cycles, count_clr, ext_trig,
      output trig_waiting, board_ldac,
      input  trigger, ldac_shared, trig_count, missed_trig, ldac_skew, state
   );

   // Scheduler side
   modport slave (
      input  enable, board_mask, lockout_cycles, count_clr, ext_trig,
      input  trig_waiting, board_ldac,
      output trigger, ldac_shared, trig_count, missed_trig, ldac_skew, state
   );
endinterface

// File: rtl/trig_ldac_sched.sv
// rtl/trig_ldac_sched.sv - external trigger scheduler with shared LDAC combining
module trig_ldac_sched #(
   parameter int NUM_BOARDS = 8,
   parameter int LOCKOUT_W  = 25
) (
   input  logic              clk,
   input  logic              resetn,
   trig_ldac_sched_if.slave  sif
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_FIRE    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   state_t                r_state;
   logic [NUM_BOARDS-1:0] r_mask_q;
   logic [LOCKOUT_W-1:0]  r_lock;
   logic                  r_trigger;
   logic                  r_ldac_shared;
   logic [31:0]           r_trig_count;
   logic                  r_missed;
   logic                  r_skew;
   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_sync3;
   logic [2:0]            r_vld;

   logic [NUM_BOARDS-1:0] w_ldac_m;
   logic                  w_trig_evt;
   logic                  w_all_waiting;
   logic                  w_miss_evt;
   logic                  w_skew_evt;

   // r_vld marks when r_sync3 holds a real post-reset sample, so a level held
   // high through reset is never mistaken for a rising edge
   assign w_trig_evt    = r_sync2 & ~r_sync3 & r_vld[2];
   assign w_ldac_m      = sif.board_ldac & r_mask_q;
   assign w_all_waiting = ((sif.trig_waiting & r_mask_q) == r_mask_q) && (r_mask_q != '0);
   assign w_miss_evt    = w_trig_evt && sif.enable &&
                          (((r_state == ST_ARMED) && !w_all_waiting) || (r_state == ST_LOCKOUT));
   assign w_skew_evt    = (r_state != ST_IDLE) && (w_ldac_m != '0) && (w_ldac_m != r_mask_q);

   // Two-flop synchronizer plus edge-detect flop for the external trigger
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
         r_vld   <= 3'b000;
      end else begin
         r_sync1 <= sif.ext_trig;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_vld   <= {r_vld[1:0], 1'b1};
      end
   end

   // Scheduler FSM; trigger is registered alongside entry into FIRE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_mask_q  <= '0;
         r_lock    <= '0;
         r_trigger <= 1'b0;
      end else begin
         r_trigger <= 1'b0;
         if (!sif.enable) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_mask_q <= sif.board_mask;
                  r_state  <= ST_ARMED;
               end
               ST_ARMED: begin
                  if (w_trig_evt && w_all_waiting) begin
                     r_state   <= ST_FIRE;
                     r_trigger <= 1'b1;
                  end
               end
               ST_FIRE: begin
                  r_lock  <= sif.lockout_cycles;
                  r_state <= (sif.lockout_cycles == '0) ? ST_ARMED : ST_LOCKOUT;
               end
               ST_LOCKOUT: begin
                  if (r_lock <= LOCKOUT_W'(1)) begin
                     r_lock  <= '0;
                     r_state <= ST_ARMED;
                  end else begin
                     r_lock <= r_lock - LOCKOUT_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Trigger counter: a FIRE cycle always counts, even against a coincident clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_trig_count <= '0;
      end else if (r_state == ST_FIRE) begin
         r_trig_count <= (sif.count_clr ? 32'd0 : r_trig_count) + 32'd1;
      end else if (sif.count_clr) begin
         r_trig_count <= '0;
      end
   end

   // Shared LDAC and sticky status flags; a new event beats a coincident clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ldac_shared <= 1'b0;
         r_missed      <= 1'b0;
         r_skew        <= 1'b0;
      end else begin
         r_ldac_shared <= (r_state != ST_IDLE) && (|w_ldac_m);
         r_missed      <= (r_missed & ~sif.count_clr) | w_miss_evt;
         r_skew        <= (r_skew & ~sif.count_clr) | w_skew_evt;
      end
   end

   assign sif.trigger     = r_trigger;
   assign sif.ldac_shared = r_ldac_shared;
   assign sif.trig_count  = r_trig_count;
   assign sif.missed_trig = r_missed;
   assign sif.ldac_skew   = r_skew;
   assign sif.state       = r_state;
endmodule

// File: tb/tb_trig_ldac_sched.sv
// tb/tb_trig_ldac_sched.sv - directed self-checking bench for trig_ldac_sched
module tb_trig_ldac_sched;
   localparam int NB = 8;
   localparam int LW = 25;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;
   int   pulses;

   trig_ldac_sched_if #(.NUM_BOARDS(NB), .LOCKOUT_W(LW)) bif ();

   trig_ldac_sched #(.NUM_BOARDS(NB), .LOCKOUT_W(LW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .sif    (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bif.enable = 1'b0;
      bif.board_mask = '0;
      bif.lockout_cycles = '0;
      bif.count_clr = 1'b0;
      bif.ext_trig = 1'b0;
      bif.trig_waiting = '0;
      bif.board_ldac = '0;

      // reset values
      tick(); tick();
      chk("rst_state", 32'(bif.state), 0);
      chk("rst_trigger", 32'(bif.trigger), 0);
      chk("rst_ldac", 32'(bif.ldac_shared), 0);
      chk("rst_count", bif.trig_count, 0);
      chk("rst_missed", 32'(bif.missed_trig), 0);
      chk("rst_skew", 32'(bif.ldac_skew), 0);
      resetn = 1'b1;

      // IDLE ignores LDAC requests
      bif.board_mask = 8'h0F;
      bif.board_ldac = 8'h05;
      tick(); tick(); tick();
      chk("idle_ldac", 32'(bif.ldac_shared), 0);
      chk("idle_skew", 32'(bif.ldac_skew), 0);
      chk("idle_state", 32'(bif.state), 0);
      bif.board_ldac = '0;

      // basic trigger, lockout 10
      bif.lockout_cycles = 25'd10;
      bif.trig_waiting = 8'h0F;
      bif.enable = 1'b1;
      tick();
      chk("armed", 32'(bif.state), 1);
      bif.ext_trig = 1'b1;
      tick(); tick();
      chk("pre_fire_trig", 32'(bif.trigger), 0);
      tick();
      chk("fire_trig", 32'(bif.trigger), 1);
      chk("fire_state", 32'(bif.state), 2);
      bif.ext_trig = 1'b0;
      tick();
      chk("post_fire_trig", 32'(bif.trigger), 0);
      chk("lockout_state", 32'(bif.state), 3);
      chk("count_1", bif.trig_count, 1);
      repeat (9) tick();
      chk("lockout_last", 32'(bif.state), 3);
      tick();
      chk("lockout_done", 32'(bif.state), 1);

      // not all masked boards waiting -> missed
      bif.count_clr = 1'b1;
      tick();
      bif.count_clr = 1'b0;
      chk("clr_count", bif.trig_count, 0);
      bif.trig_waiting = 8'h07;
      bif.ext_trig = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bif.trigger) pulses++;
      end
      chk("miss_pulses", pulses, 0);
      chk("miss_flag", 32'(bif.missed_trig), 1);
      chk("miss_count", bif.trig_count, 0);
      chk("miss_state", 32'(bif.state), 1);

      // second edge inside a 100-cycle lockout
      bif.ext_trig = 1'b0;
      bif.trig_waiting = 8'h0F;
      bif.lockout_cycles = 25'd100;
      bif.count_clr = 1'b1;
      tick(); tick();
      bif.count_clr = 1'b0;
      chk("clr_missed", 32'(bif.missed_trig), 0);
      bif.ext_trig = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bif.trigger) pulses++;
         if (i == 4) bif.ext_trig = 1'b0;
         if (i == 18) bif.ext_trig = 1'b1;
      end
      chk("lk_pulses", pulses, 1);
      chk("lk_missed", 32'(bif.missed_trig), 1);
      chk("lk_count", bif.trig_count, 1);
      chk("lk_state", 32'(bif.state), 3);

      // enable dropped during lockout
      bif.enable = 1'b0;
      bif.ext_trig = 1'b0;
      tick();
      chk("dis_state", 32'(bif.state), 0);
      chk("dis_trig", 32'(bif.trigger), 0);

      // LDAC combining and skew, mask 0x03
      bif.board_mask = 8'h03;
      bif.enable = 1'b1;
      tick();
      chk("armed2", 32'(bif.state), 1);
      bif.board_ldac = 8'h03;
      tick();
      chk("ldac_a", 32'(bif.ldac_shared), 1);
      chk("skew_a", 32'(bif.ldac_skew), 0);
      bif.board_ldac = 8'h01;
      tick();
      chk("ldac_b", 32'(bif.ldac_shared), 1);
      chk("skew_b", 32'(bif.ldac_skew), 1);
      bif.board_ldac = 8'h00;
      tick();
      chk("ldac_c", 32'(bif.ldac_shared), 0);
      chk("skew_c", 32'(bif.ldac_skew), 1);

      // count_clr coincident with FIRE, zero lockout
      bif.lockout_cycles = '0;
      bif.ext_trig = 1'b1;
      tick(); tick(); tick();
      chk("fire2_trig", 32'(bif.trigger), 1);
      bif.count_clr = 1'b1;
      tick();
      bif.count_clr = 1'b0;
      chk("clr_fire_count", bif.trig_count, 1);
      chk("zero_lock_state", 32'(bif.state), 1);
      chk("clr_fire_skew", 32'(bif.ldac_skew), 0);
      chk("clr_fire_missed", 32'(bif.missed_trig), 0);

      // reset asserted during FIRE
      bif.ext_trig = 1'b0;
      tick(); tick();
      bif.ext_trig = 1'b1;
      tick(); tick(); tick();
      chk("fire3_trig", 32'(bif.trigger), 1);
      #1 resetn = 1'b0;
      #1;
      chk("rstfire_trig", 32'(bif.trigger), 0);
      chk("rstfire_state", 32'(bif.state), 0);
      chk("rstfire_count", bif.trig_count, 0);
      chk("rstfire_ldac", 32'(bif.ldac_shared), 0);
      #1 resetn = 1'b1;

      // ext_trig level held through reset must not trigger
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bif.trigger) pulses++;
      end
      chk("held_pulses", pulses, 0);
      chk("held_state", 32'(bif.state), 1);
      chk("held_count", bif.trig_count, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
